axi4_lite_rr_master: RTL and testbench

Two-requester AXI4-Lite master with round-robin arbitration. It lets two internal clients (for example, a CPU bridge and a DMA/config sequencer) share one AXI4-Lite slave register bank. Each client issues single read or write commands over a simple valid/ready port. The block serializes them, one AXI transaction outstanding at a time, and returns data and response to the winning client.

---
 rtl/axi4_lite_rr_master_if.sv | 51 +++++
 rtl/axi4_lite_rr_master.sv | 145 ++++++++++++++
 tb/tb_axi4_lite_rr_master.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_rr_master_if.sv
// Bundle of requester-side and AXI4-Lite master-side signals for axi4_lite_rr_master.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface axi4_lite_rr_master_if #(
    parameter int unsigned ADDRESS    = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // Requester 0 / 1 command ports
    logic                  REQ_VALID0, REQ_VALID1;
    logic                  REQ_READY0, REQ_READY1;
    logic                  REQ_WRITE0, REQ_WRITE1;
    logic [ADDRESS-1:0]    REQ_ADDR0, REQ_ADDR1;
    logic [DATA_WIDTH-1:0] REQ_WDATA0, REQ_WDATA1;
    logic [STRB_WIDTH-1:0] REQ_WSTRB0, REQ_WSTRB1;
    // Shared completion
    logic                  RSP_VALID0, RSP_VALID1;
    logic [DATA_WIDTH-1:0] RSP_RDATA;
    logic [1:0]            RSP_RESP;
    // AXI4-Lite master channels
    logic [ADDRESS-1:0]    M_AWADDR;
    logic                  M_AWVALID, M_AWREADY;
    logic [DATA_WIDTH-1:0] M_WDATA;
    logic [STRB_WIDTH-1:0] M_WSTRB;
    logic                  M_WVALID, M_WREADY;
    logic [1:0]            M_BRESP;
    logic                  M_BVALID, M_BREADY;
    logic [ADDRESS-1:0]    M_ARADDR;
    logic                  M_ARVALID, M_ARREADY;
    logic [DATA_WIDTH-1:0] M_RDATA;
    logic [1:0]            M_RRESP;
    logic                  M_RVALID, M_RREADY;

    modport master (
        input  REQ_VALID0, REQ_VALID1, REQ_WRITE0, REQ_WRITE1, REQ_ADDR0, REQ_ADDR1,
        input  REQ_WDATA0, REQ_WDATA1, REQ_WSTRB0, REQ_WSTRB1,
        output REQ_READY0, REQ_READY1, RSP_VALID0, RSP_VALID1, RSP_RDATA, RSP_RESP,
        output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
        output M_ARADDR, M_ARVALID, M_RREADY,
        input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID
    );

    modport slave (
        output REQ_VALID0, REQ_VALID1, REQ_WRITE0, REQ_WRITE1, REQ_ADDR0, REQ_ADDR1,
        output REQ_WDATA0, REQ_WDATA1, REQ_WSTRB0, REQ_WSTRB1,
        input  REQ_READY0, REQ_READY1, RSP_VALID0, RSP_VALID1, RSP_RDATA, RSP_RESP,
        input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
        input  M_ARADDR, M_ARVALID, M_RREADY,
        output M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID
    );
endinterface

// File: rtl/axi4_lite_rr_master.sv
// Two-requester AXI4-Lite master. Round-robin arbitration in idle, one AXI transaction
// outstanding at a time, completion pulsed back to the winning requester.
module axi4_lite_rr_master #(
    parameter int unsigned ADDRESS    = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    axi4_lite_rr_master_if.master bus
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {StIdle, StWrite, StWresp, StRaddr, StRdata, StResp} state_e;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic [ADDRESS-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic                  grant0, grant1;
    logic                  grant_write;

    // Arbitration: a lone requester wins; on a tie the one not granted last time wins
    always_comb begin
        grant0      = bus.REQ_VALID0 & (~bus.REQ_VALID1 | last_grant_q);
        grant1      = bus.REQ_VALID1 & (~bus.REQ_VALID0 | ~last_grant_q);
        grant_write = grant1 ? bus.REQ_WRITE1 : bus.REQ_WRITE0;
    end

    // Next-state and command capture
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
        unique case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    addr_d       = grant1 ? bus.REQ_ADDR1  : bus.REQ_ADDR0;
                    wdata_d      = grant1 ? bus.REQ_WDATA1 : bus.REQ_WDATA0;
                    wstrb_d      = grant1 ? bus.REQ_WSTRB1 : bus.REQ_WSTRB0;
                    if (grant_write) begin
                        state_d   = StWrite;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRaddr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                // AW and W complete independently, in any order
                if (bus.M_AWREADY) awvalid_d = 1'b0;
                if (bus.M_WREADY)  wvalid_d  = 1'b0;
                if ((!awvalid_q || bus.M_AWREADY) && (!wvalid_q || bus.M_WREADY)) begin
                    state_d = StWresp;
                end
            end
            StWresp: begin
                if (bus.M_BVALID) begin
                    resp_d  = bus.M_BRESP;
                    rdata_d = '0;
                    state_d = StResp;
                end
            end
            StRaddr: begin
                if (bus.M_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (bus.M_RVALID) begin
                    resp_d  = bus.M_RRESP;
                    rdata_d = bus.M_RDATA;
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and command registers; reset abandons any transaction in flight
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
        end
    end

    // Ready is gated by reset so nothing is accepted while reset is held
    assign bus.REQ_READY0 = ARESETN & (state_q == StIdle) & grant0;
    assign bus.REQ_READY1 = ARESETN & (state_q == StIdle) & grant1;
    assign bus.RSP_VALID0 = (state_q == StResp) & ~owner_q;
    assign bus.RSP_VALID1 = (state_q == StResp) & owner_q;
    assign bus.RSP_RDATA  = rdata_q;
    assign bus.RSP_RESP   = resp_q;
    assign bus.M_AWADDR   = addr_q;
    assign bus.M_AWVALID  = awvalid_q;
    assign bus.M_WDATA    = wdata_q;
    assign bus.M_WSTRB    = wstrb_q;
    assign bus.M_WVALID   = wvalid_q;
    assign bus.M_BREADY   = (state_q == StWresp);
    assign bus.M_ARADDR   = addr_q;
    assign bus.M_ARVALID  = arvalid_q;
    assign bus.M_RREADY   = (state_q == StRdata);
endmodule

// File: tb/tb_axi4_lite_rr_master.sv
// Directed bench for axi4_lite_rr_master: behavioural AXI4-Lite slave with programmable
// delays plus two requester drivers; expected values are hand-computed constants.
module tb_axi4_lite_rr_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_lite_rr_master_if #(.ADDRESS(32), .DATA_WIDTH(32)) bus ();

    axi4_lite_rr_master #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .bus     (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned n_rsp0 = 0, n_rsp1 = 0, n_aw_hs = 0, n_w_hs = 0;
    int unsigned aw_hi = 0, w_hi = 0, bready_phases = 0;
    int          grants[$];
    int          aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'd0, rresp_cfg = 2'd0;
    logic [31:0] last_awaddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] mem [64];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit r, input bit v, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        if (!r) begin
            bus.REQ_VALID0 = v; bus.REQ_WRITE0 = wr; bus.REQ_ADDR0 = a;
            bus.REQ_WDATA0 = d; bus.REQ_WSTRB0 = s;
        end else begin
            bus.REQ_VALID1 = v; bus.REQ_WRITE1 = wr; bus.REQ_ADDR1 = a;
            bus.REQ_WDATA1 = d; bus.REQ_WSTRB1 = s;
        end
    endtask

    // One command: wait for grant, drop valid, wait for the completion pulse
    task automatic do_cmd(input string tag, input bit r, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic [1:0] rs, output int lat);
        bit seen = 1'b0;
        int t0 = 0;
        rd = '0; rs = '0; lat = -1;
        tick();
        drive_req(r, 1'b1, wr, a, d, s);
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (r ? bus.REQ_READY1 : bus.REQ_READY0) begin
                seen = 1'b1;
                t0   = int'(cyc);
            end
        end
        if (!seen) begin
            check_eq({tag, "_grant_timeout"}, 32'd0, 32'd1);
            drive_req(r, 1'b0, 1'b0, '0, '0, '0);
            return;
        end
        tick();
        drive_req(r, 1'b0, 1'b0, '0, '0, '0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (r ? bus.RSP_VALID1 : bus.RSP_VALID0) begin
                seen = 1'b1;
                lat  = int'(cyc) - t0;
                rd   = bus.RSP_RDATA;
                rs   = bus.RSP_RESP;
            end
        end
        if (!seen) check_eq({tag, "_rsp_timeout"}, 32'd0, 32'd1);
    endtask

    // Keep valid high across n write commands, changing the command after each grant
    task automatic stream(input string tag, input bit r, input int n, input logic [31:0] base,
                          input logic [31:0] dbase);
        bit seen;
        tick();
        for (int k = 0; k < n; k++) begin
            drive_req(r, 1'b1, 1'b1, base + 32'(4 * k), dbase + 32'(k), 4'hF);
            seen = 1'b0;
            for (int i = 0; i < 80 && !seen; i++) begin
                @(negedge clk);
                seen = r ? bus.REQ_READY1 : bus.REQ_READY0;
            end
            if (!seen) begin
                check_eq({tag, "_timeout"}, 32'd0, 32'd1);
                break;
            end
            tick();
        end
        drive_req(r, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Observation at the falling edge, away from the active edge
    initial begin : monitor
        bit bready_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.RSP_VALID0) n_rsp0++;
            if (bus.RSP_VALID1) n_rsp1++;
            if (bus.REQ_READY0) grants.push_back(0);
            if (bus.REQ_READY1) grants.push_back(1);
            if (bus.M_AWVALID) aw_hi++;
            if (bus.M_WVALID) w_hi++;
            if (bus.M_BREADY && !bready_prev) bready_phases++;
            bready_prev = bus.M_BREADY;
        end
    end

    // Behavioural slave: readies after programmable delays, response delays, word memory
    initial begin : slave
        bit aw_done = 0, w_done = 0, b_pend = 0, r_pend = 0;
        bit awv = 0, wv = 0, arv = 0, br = 0, rr = 0;
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_cnt = 0;
        logic [31:0] ar_addr = '0, rd_h = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        bus.M_AWREADY = 0; bus.M_WREADY = 0; bus.M_BVALID = 0; bus.M_BRESP = '0;
        bus.M_ARREADY = 0; bus.M_RVALID = 0; bus.M_RDATA = '0; bus.M_RRESP = '0;
        forever begin
            @(negedge clk);
            awv = bus.M_AWVALID; wv = bus.M_WVALID; arv = bus.M_ARVALID;
            br = bus.M_BREADY; rr = bus.M_RREADY;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0;
                bus.M_AWREADY = 0; bus.M_WREADY = 0; bus.M_BVALID = 0;
                bus.M_ARREADY = 0; bus.M_RVALID = 0;
            end else begin
                if (awv && bus.M_AWREADY) begin aw_done = 1; n_aw_hs++; end
                if (wv && bus.M_WREADY) begin w_done = 1; n_w_hs++; end
                if (bus.M_BVALID && br) bus.M_BVALID = 0;
                if (arv && bus.M_ARREADY) begin r_pend = 1; r_cnt = 0; rd_h = mem[ar_addr[7:2]]; end
                if (bus.M_RVALID && rr) bus.M_RVALID = 0;
                if (aw_done && w_done) begin
                    aw_done = 0; w_done = 0; b_pend = 1; b_cnt = 0;
                    for (int i = 0; i < 4; i++) begin
                        if (last_wstrb[i]) mem[last_awaddr[7:2]][8*i +: 8] = last_wdata[8*i +: 8];
                    end
                end
                if (b_pend) begin
                    if (b_cnt == b_dly) begin
                        bus.M_BVALID = 1; bus.M_BRESP = bresp_cfg; b_pend = 0;
                    end else b_cnt++;
                end
                if (r_pend) begin
                    if (r_cnt == r_dly) begin
                        bus.M_RVALID = 1; bus.M_RDATA = rd_h; bus.M_RRESP = rresp_cfg; r_pend = 0;
                    end else r_cnt++;
                end
                if (bus.M_AWVALID) begin
                    bus.M_AWREADY = (aw_cnt >= aw_dly); last_awaddr = bus.M_AWADDR; aw_cnt++;
                end else begin
                    bus.M_AWREADY = 0; aw_cnt = 0;
                end
                if (bus.M_WVALID) begin
                    bus.M_WREADY = (w_cnt >= w_dly); last_wdata = bus.M_WDATA;
                    last_wstrb = bus.M_WSTRB; w_cnt++;
                end else begin
                    bus.M_WREADY = 0; w_cnt = 0;
                end
                bus.M_ARREADY = bus.M_ARVALID;
                if (bus.M_ARVALID) ar_addr = bus.M_ARADDR;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] rd0, rd1;
        logic [1:0]  rs0, rs1;
        int          lat0, lat1;
        int unsigned base0, base1, busy_ready1;
        logic [7:0]  gv;
        bit          seen;

        drive_req(1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 4'hF);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);

        // Reset state: all outputs low even with a requester pending
        repeat (2) @(negedge clk);
        check_eq("reset_ctrl", {bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID, bus.M_BREADY,
                 bus.M_RREADY, bus.RSP_VALID0, bus.RSP_VALID1, bus.REQ_READY0, bus.REQ_READY1},
                 32'd0);
        check_eq("reset_awaddr", bus.M_AWADDR, 32'd0);
        check_eq("reset_araddr", bus.M_ARADDR, 32'd0);
        check_eq("reset_wdata", bus.M_WDATA, 32'd0);
        check_eq("reset_wstrb_resp", {bus.M_WSTRB, bus.RSP_RESP}, 32'd0);
        check_eq("reset_rdata", bus.RSP_RDATA, 32'd0);
        drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b1;

        // Single write, zero-wait slave
        do_cmd("wr0", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd0, rs0, lat0);
        check_eq("wr0_awaddr", last_awaddr, 32'h10);
        check_eq("wr0_wdata", last_wdata, 32'hDEAD_BEEF);
        check_eq("wr0_wstrb", 32'(last_wstrb), 32'hF);
        check_eq("wr0_hs_count", {n_aw_hs[15:0], n_w_hs[15:0]}, 32'h0001_0001);
        check_eq("wr0_resp", 32'(rs0), 32'd0);
        check_eq("wr0_rdata", rd0, 32'd0);
        check_eq("wr0_latency", 32'(lat0), 32'd3);

        // Read-back on requester 1
        base0 = n_rsp0;
        do_cmd("rd1", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd1, rs1, lat1);
        check_eq("rd1_rdata", rd1, 32'hDEAD_BEEF);
        check_eq("rd1_resp", 32'(rs1), 32'd0);
        check_eq("rd1_latency", 32'(lat1), 32'd3);
        check_eq("rd1_no_rsp0", n_rsp0 - base0, 32'd0);

        // Simultaneous streams after reset: strict alternation starting with requester 0
        do_reset();
        grants.delete();
        base0 = n_rsp0; base1 = n_rsp1;
        fork
            stream("tie_r0", 1'b0, 4, 32'h20, 32'hA0);
            stream("tie_r1", 1'b1, 4, 32'h40, 32'hB0);
        join
        repeat (10) tick();
        gv = '0;
        for (int k = 0; k < grants.size() && k < 8; k++) gv[k] = (grants[k] != 0);
        check_eq("tie_grant_count", 32'(grants.size()), 32'd8);
        check_eq("tie_grant_order", 32'(gv), 32'hAA);
        check_eq("tie_rsp0", n_rsp0 - base0, 32'd4);
        check_eq("tie_rsp1", n_rsp1 - base1, 32'd4);
        check_eq("tie_mem_r0", mem[11], 32'hA3);
        check_eq("tie_mem_r1", mem[19], 32'hB3);

        // AW three cycles before W
        aw_dly = 0; w_dly = 3;
        aw_hi = 0; w_hi = 0; bready_phases = 0;
        do_cmd("split", 1'b0, 1'b1, 32'h18, 32'h0000_5A5A, 4'h3, rd0, rs0, lat0);
        check_eq("split_aw_cycles", aw_hi, 32'd1);
        check_eq("split_w_cycles", w_hi, 32'd4);
        check_eq("split_bready_phases", bready_phases, 32'd1);
        check_eq("split_latency", 32'(lat0), 32'd6);

        // W two cycles before AW
        aw_dly = 2; w_dly = 0;
        aw_hi = 0; w_hi = 0; bready_phases = 0;
        do_cmd("rev", 1'b0, 1'b1, 32'h1C, 32'h1111_2222, 4'hF, rd0, rs0, lat0);
        check_eq("rev_aw_cycles", aw_hi, 32'd3);
        check_eq("rev_w_cycles", w_hi, 32'd1);
        check_eq("rev_bready_phases", bready_phases, 32'd1);
        check_eq("rev_latency", 32'(lat0), 32'd5);
        check_eq("rev_mem", mem[7], 32'h1111_2222);
        aw_dly = 0;

        // Slow SLVERR write response while requester 1 waits
        b_dly = 5; bresp_cfg = 2'd2;
        busy_ready1 = 0;
        base0 = n_rsp0;
        fork
            do_cmd("bp_wr0", 1'b0, 1'b1, 32'h24, 32'hCAFE_0000, 4'hF, rd0, rs0, lat0);
            begin
                repeat (2) tick();
                do_cmd("bp_rd1", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd1, rs1, lat1);
            end
            begin
                for (int i = 0; i < 60 && n_rsp0 == base0; i++) begin
                    @(negedge clk);
                    if (bus.REQ_READY1) busy_ready1++;
                end
            end
        join
        check_eq("bp_resp", 32'(rs0), 32'd2);
        check_eq("bp_latency", 32'(lat0), 32'd8);
        check_eq("bp_ready1_while_busy", busy_ready1, 32'd0);
        check_eq("bp_rd1_rdata", rd1, 32'hDEAD_BEEF);
        b_dly = 0; bresp_cfg = 2'd0;

        // Reset while in the read data phase
        r_dly = 10;
        base0 = n_rsp0; base1 = n_rsp1;
        tick();
        drive_req(1'b0, 1'b1, 1'b0, 32'h10, '0, '0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.REQ_READY0;
        end
        check_eq("mid_grant", 32'(seen), 32'd1);
        tick();
        drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.M_RREADY;
        end
        check_eq("mid_in_rdata", 32'(seen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_reset_ctrl", {bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID, bus.M_BREADY,
                 bus.M_RREADY, bus.RSP_VALID0, bus.RSP_VALID1, bus.REQ_READY0, bus.REQ_READY1},
                 32'd0);
        check_eq("mid_reset_araddr", bus.M_ARADDR, 32'd0);
        check_eq("mid_reset_rdata", bus.RSP_RDATA, 32'd0);
        check_eq("mid_reset_resp", 32'(bus.RSP_RESP), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        r_dly = 0;
        repeat (15) tick();
        check_eq("mid_no_rsp", (n_rsp0 - base0) + (n_rsp1 - base1), 32'd0);

        // First tie after reset goes to requester 0 again
        grants.delete();
        fork
            do_cmd("post_r0", 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd0, rs0, lat0);
            do_cmd("post_r1", 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, rd1, rs1, lat1);
        join
        check_eq("post_grant_count", 32'(grants.size()), 32'd2);
        check_eq("post_first_grant", (grants.size() > 0) ? 32'(grants[0]) : 32'hFFFF_FFFF,
                 32'd0);
        check_eq("post_r0_rdata", rd0, 32'hDEAD_BEEF);
        check_eq("post_r1_rdata", rd1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
